// File: rtl/slave_in_port.sv
// ---------------------------------------------------------------------------
// slave_in_port
//
// Receiving end of the serial master-to-slave bus path. After a valid/ready
// handshake the port shifts in a serial address stream and, for writes, a
// serial data stream (both LSB first). It then presents the assembled
// parallel address/data to the slave core together with a one-cycle
// completion strobe.
//
// Ports:
//   clk           bus clock, all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   master_valid  master drives a valid transfer (dropping it mid-transfer aborts)
//   write_en      transfer is a write (sampled only at the handshake)
//   read_en       transfer is a read  (sampled only at the handshake)
//   rx_address    serial address bit, LSB first
//   rx_data       serial write-data bit, LSB first
//   slave_ready   port can accept a new transfer
//   address       last completed address (parallel)
//   data          last completed write data (parallel)
//   rx_write      1 = last completed transfer was a write, 0 = read
//   rx_done       one-cycle strobe: address/data/rx_write were just updated
// ---------------------------------------------------------------------------
module slave_in_port #(
    parameter int ADDR_LEN = 12,
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic [ADDR_LEN-1:0] address,
    output logic [DATA_LEN-1:0] data,
    output logic                rx_write,
    output logic                rx_done
);

    // A transfer lasts as many cycles as the longer of the two streams.
    localparam int L     = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CNT_W = $clog2(L + 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    bitCount_q;
    logic [ADDR_LEN-1:0] addrShift_q;
    logic [DATA_LEN-1:0] dataShift_q;
    logic                writeFlag_q;
    logic                slaveReady_q;
    logic [ADDR_LEN-1:0] address_q;
    logic [DATA_LEN-1:0] data_q;
    logic                rxWrite_q;
    logic                rxDone_q;

    logic                handshake;
    logic                captureWrite;
    logic                lastBit;
    logic [ADDR_LEN-1:0] addrShift_d;
    logic [DATA_LEN-1:0] dataShift_d;

    // Handshake qualification and the direction that governs the current
    // capture. In IDLE the direction comes straight from write_en (it is
    // being latched on this very edge); during RECEIVE the latched flag is
    // used so that write_en/read_en are ignored once a transfer is running.
    always_comb begin
        handshake    = (state_q == IDLE) && master_valid && slaveReady_q
                       && (write_en ^ read_en);
        captureWrite = (state_q == IDLE) ? write_en : writeFlag_q;
        lastBit      = (bitCount_q == CNT_W'(L - 1));
    end

    // Next shift-register contents with the current serial bit dropped into
    // the slot selected by the bit counter. Slots beyond a stream's length
    // simply do not exist, so surplus bits of the shorter stream vanish.
    // These values feed both the shift registers and, on the final bit, the
    // parallel outputs, so completion sees the last bit on the same edge.
    always_comb begin
        addrShift_d = addrShift_q;
        dataShift_d = dataShift_q;
        for (int i = 0; i < ADDR_LEN; i++) begin
            if (bitCount_q == CNT_W'(i)) begin
                addrShift_d[i] = rx_address;
            end
        end
        if (captureWrite) begin
            for (int i = 0; i < DATA_LEN; i++) begin
                if (bitCount_q == CNT_W'(i)) begin
                    dataShift_d[i] = rx_data;
                end
            end
        end
    end

    // Transfer FSM with registered outputs. rx_done defaults low every edge
    // and is only raised on the completion edge. Completion returns straight
    // to IDLE with slave_ready high, which lets a new handshake land on the
    // edge that ends the rx_done cycle. An abort (master_valid dropped during
    // RECEIVE) throws the partial shift contents away and leaves the
    // previously completed outputs untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bitCount_q   <= '0;
            addrShift_q  <= '0;
            dataShift_q  <= '0;
            writeFlag_q  <= 1'b0;
            slaveReady_q <= 1'b1;
            address_q    <= '0;
            data_q       <= '0;
            rxWrite_q    <= 1'b0;
            rxDone_q     <= 1'b0;
        end else begin
            rxDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        writeFlag_q <= write_en;
                        if (L == 1) begin
                            address_q    <= addrShift_d;
                            if (write_en) begin
                                data_q <= dataShift_d;
                            end
                            rxWrite_q    <= write_en;
                            rxDone_q     <= 1'b1;
                            slaveReady_q <= 1'b1;
                            bitCount_q   <= '0;
                            addrShift_q  <= '0;
                            dataShift_q  <= '0;
                        end else begin
                            addrShift_q  <= addrShift_d;
                            dataShift_q  <= dataShift_d;
                            bitCount_q   <= CNT_W'(1);
                            slaveReady_q <= 1'b0;
                            state_q      <= RECEIVE;
                        end
                    end
                end
                RECEIVE: begin
                    if (!master_valid) begin
                        state_q      <= IDLE;
                        slaveReady_q <= 1'b1;
                        bitCount_q   <= '0;
                        addrShift_q  <= '0;
                        dataShift_q  <= '0;
                    end else if (lastBit) begin
                        address_q    <= addrShift_d;
                        if (writeFlag_q) begin
                            data_q <= dataShift_d;
                        end
                        rxWrite_q    <= writeFlag_q;
                        rxDone_q     <= 1'b1;
                        slaveReady_q <= 1'b1;
                        bitCount_q   <= '0;
                        addrShift_q  <= '0;
                        dataShift_q  <= '0;
                        state_q      <= IDLE;
                    end else begin
                        addrShift_q <= addrShift_d;
                        dataShift_q <= dataShift_d;
                        bitCount_q  <= bitCount_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    slaveReady_q <= 1'b1;
                    bitCount_q   <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        slave_ready = slaveReady_q;
        address     = address_q;
        data        = data_q;
        rx_write    = rxWrite_q;
        rx_done     = rxDone_q;
    end

endmodule

// File: tb/tb_slave_in_port.sv
// ---------------------------------------------------------------------------
// tb_slave_in_port
//
// Self-checking bench for slave_in_port. A default instance (12-bit address,
// 8-bit data) is driven from a table of transfers plus hand-written
// back-to-back and reset-mid-transfer sequences; a second instance with a
// 4-bit address exercises the shorter-address configuration. Expected
// completions are queued at the handshake and popped when rx_done fires.
// ---------------------------------------------------------------------------
module tb_slave_in_port;

    localparam int L_A = 12;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [11:0] addr;
        logic [7:0]  dat;
        int          abortAt;
        logic        expDone;
        logic [11:0] expAddr;
        logic [7:0]  expData;
        logic        expWrite;
    } vec_t;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        logic        w;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        masterValid;
    logic        writeEn;
    logic        readEn;
    logic        rxAddress;
    logic        rxData;
    logic        slaveReady;
    logic [11:0] address;
    logic [7:0]  data;
    logic        rxWrite;
    logic        rxDone;

    logic        bMasterValid;
    logic        bWriteEn;
    logic        bReadEn;
    logic        bRxAddress;
    logic        bRxData;
    logic        bSlaveReady;
    logic [3:0]  bAddress;
    logic [7:0]  bData;
    logic        bRxWrite;
    logic        bRxDone;

    int   checks;
    int   failures;
    exp_t sbQ[$];
    exp_t monExp;
    vec_t vecs[8];

    slave_in_port #(
        .ADDR_LEN(12),
        .DATA_LEN(8)
    ) dutA (
        .clk         (clk),
        .reset       (reset),
        .master_valid(masterValid),
        .write_en    (writeEn),
        .read_en     (readEn),
        .rx_address  (rxAddress),
        .rx_data     (rxData),
        .slave_ready (slaveReady),
        .address     (address),
        .data        (data),
        .rx_write    (rxWrite),
        .rx_done     (rxDone)
    );

    slave_in_port #(
        .ADDR_LEN(4),
        .DATA_LEN(8)
    ) dutB (
        .clk         (clk),
        .reset       (reset),
        .master_valid(bMasterValid),
        .write_en    (bWriteEn),
        .read_en     (bReadEn),
        .rx_address  (bRxAddress),
        .rx_data     (bRxData),
        .slave_ready (bSlaveReady),
        .address     (bAddress),
        .data        (bData),
        .rx_write    (bRxWrite),
        .rx_done     (bRxDone)
    );

    // Free-running 10 ns bus clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its required value and keep count.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one transfer on the default instance: handshake, then one serial
    // bit per cycle, checking the busy window and the completion strobe.
    // Illegal enable combinations and aborts are handled here too.
    task automatic applyStimulus(input vec_t v);
        bit legal;
        legal       = v.wr ^ v.rd;
        masterValid = 1'b1;
        writeEn     = v.wr;
        readEn      = v.rd;
        rxAddress   = v.addr[0];
        rxData      = v.wr ? v.dat[0] : 1'b0;
        if (!legal) begin
            repeat (2) begin
                tick();
                checkOutput("illegal ready", 32'(slaveReady), 32'd1);
                checkOutput("illegal done", 32'(rxDone), 32'd0);
            end
            return;
        end
        if (v.abortAt == 0) begin
            sbQ.push_back('{v.expAddr, v.expData, v.expWrite});
        end
        for (int k = 1; k < L_A; k++) begin
            tick();
            checkOutput("busy ready", 32'(slaveReady), 32'd0);
            checkOutput("busy done", 32'(rxDone), 32'd0);
            if (k == v.abortAt) begin
                masterValid = 1'b0;
                tick();
                checkOutput("abort ready", 32'(slaveReady), 32'd1);
                checkOutput("abort done", 32'(rxDone), 32'd0);
                return;
            end
            writeEn   = 1'($urandom);
            readEn    = 1'($urandom);
            rxAddress = v.addr[k[3:0]];
            if (!v.wr) begin
                rxData = k[0];
            end else if (k < 8) begin
                rxData = v.dat[k[2:0]];
            end else begin
                rxData = 1'($urandom);
            end
        end
        tick();
        checkOutput("done strobe", 32'(rxDone), 32'd1);
        checkOutput("done ready", 32'(slaveReady), 32'd1);
    endtask

    // Scoreboard: every completion on the default instance must match the
    // oldest queued expectation; a completion with nothing queued is wrong.
    always @(posedge clk) begin
        #2;
        if (rxDone === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected rx_done", 32'(rxDone), 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("sb address", 32'(address), 32'(monExp.a));
                checkOutput("sb data", 32'(data), 32'(monExp.d));
                checkOutput("sb rx_write", 32'(rxWrite), 32'(monExp.w));
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        masterValid  = 1'b0;
        writeEn      = 1'b0;
        readEn       = 1'b0;
        rxAddress    = 1'b0;
        rxData       = 1'b0;
        bMasterValid = 1'b0;
        bWriteEn     = 1'b0;
        bReadEn      = 1'b0;
        bRxAddress   = 1'b0;
        bRxData      = 1'b0;

        // Transfer table: {wr, rd, addr, data, abortAt, expDone, expAddr, expData, expWrite}
        vecs[0] = '{1'b1, 1'b0, 12'hA5C, 8'h3B, 0, 1'b1, 12'hA5C, 8'h3B, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 12'h123, 8'h00, 0, 1'b1, 12'h123, 8'h3B, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 12'hFFF, 8'hFF, 5, 1'b0, 12'h123, 8'h3B, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 12'h001, 8'h80, 0, 1'b1, 12'h001, 8'h80, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 12'hFFF, 8'hFF, 0, 1'b0, 12'h001, 8'h80, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 12'hFFF, 8'hFF, 0, 1'b0, 12'h001, 8'h80, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 12'h7FE, 8'h55, 0, 1'b1, 12'h7FE, 8'h80, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 12'h800, 8'h01, 0, 1'b1, 12'h800, 8'h01, 1'b1};

        #1 reset = 1'b1;
        #1;
        checkOutput("reset ready", 32'(slaveReady), 32'd1);
        checkOutput("reset address", 32'(address), 32'd0);
        checkOutput("reset data", 32'(data), 32'd0);
        checkOutput("reset rx_write", 32'(rxWrite), 32'd0);
        checkOutput("reset done", 32'(rxDone), 32'd0);
        checkOutput("reset B ready", 32'(bSlaveReady), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            masterValid = 1'b0;
            writeEn     = 1'b0;
            readEn      = 1'b0;
            tick();
            checkOutput("idle done low", 32'(rxDone), 32'd0);
            checkOutput("idle ready", 32'(slaveReady), 32'd1);
            checkOutput("hold address", 32'(address), 32'(vecs[i].expAddr));
            checkOutput("hold data", 32'(data), 32'(vecs[i].expData));
            checkOutput("hold rx_write", 32'(rxWrite), 32'(vecs[i].expWrite));
        end

        // Back-to-back: second handshake lands in the rx_done cycle.
        applyStimulus('{1'b1, 1'b0, 12'h5A5, 8'h69, 0, 1'b1, 12'h5A5, 8'h69, 1'b1});
        applyStimulus('{1'b0, 1'b1, 12'h0F0, 8'h00, 0, 1'b1, 12'h0F0, 8'h69, 1'b0});
        masterValid = 1'b0;
        tick();
        checkOutput("b2b address", 32'(address), 32'h0F0);
        checkOutput("b2b data", 32'(data), 32'h69);

        // Reset asserted asynchronously just after bit 6 of a write is taken.
        masterValid = 1'b1;
        writeEn     = 1'b1;
        readEn      = 1'b0;
        rxAddress   = 1'b0;
        rxData      = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rxAddress = k[0];
            rxData    = ~k[0];
        end
        tick();
        #1 reset = 1'b1;
        #1;
        checkOutput("midreset ready", 32'(slaveReady), 32'd1);
        checkOutput("midreset address", 32'(address), 32'd0);
        checkOutput("midreset data", 32'(data), 32'd0);
        checkOutput("midreset rx_write", 32'(rxWrite), 32'd0);
        checkOutput("midreset done", 32'(rxDone), 32'd0);
        masterValid = 1'b0;
        writeEn     = 1'b0;
        tick();
        reset = 1'b0;
        repeat (L_A) tick();
        checkOutput("post-reset ready", 32'(slaveReady), 32'd1);
        checkOutput("post-reset address", 32'(address), 32'd0);

        // Short-address instance: upper address bits driven high must vanish.
        begin
            logic [7:0] addrB;
            logic [7:0] datB;
            addrB        = 8'hF9;
            datB         = 8'hC6;
            bMasterValid = 1'b1;
            bWriteEn     = 1'b1;
            bReadEn      = 1'b0;
            bRxAddress   = addrB[0];
            bRxData      = datB[0];
            for (int k = 1; k < 8; k++) begin
                tick();
                checkOutput("B busy ready", 32'(bSlaveReady), 32'd0);
                checkOutput("B busy done", 32'(bRxDone), 32'd0);
                bRxAddress = addrB[k[2:0]];
                bRxData    = datB[k[2:0]];
            end
            tick();
            checkOutput("B done strobe", 32'(bRxDone), 32'd1);
            checkOutput("B address", 32'(bAddress), 32'h9);
            checkOutput("B data", 32'(bData), 32'hC6);
            checkOutput("B rx_write", 32'(bRxWrite), 32'd1);
            checkOutput("B ready", 32'(bSlaveReady), 32'd1);
            bMasterValid = 1'b0;
            tick();
            checkOutput("B done low", 32'(bRxDone), 32'd0);
        end

        checkOutput("scoreboard empty", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
